// File: rtl/binary_mul_5_arb.sv
// binary_mul_5_arb: two-requester round-robin front end for a pipelined 5x5 multiplier.
// Optional issue counter enabled by BINARY_MUL_ARB_CNT_EN.
module binary_mul_5_arb #(
   parameter int LATENCY = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [4:0]  req_a0,
   input  logic [4:0]  req_b0,
   input  logic [4:0]  req_a1,
   input  logic [4:0]  req_b1,
   output logic [4:0]  mul_a,
   output logic [4:0]  mul_b,
   output logic        mul_en,
   input  logic [9:0]  mul_p,
   output logic [1:0]  rsp_valid,
   output logic [9:0]  rsp_p
`ifdef BINARY_MUL_ARB_CNT_EN
   ,
   output logic [15:0] issue_cnt
`endif
);
   logic               ptr_q, ptr_d;
   logic [4:0]         mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic               mul_en_q, mul_en_d;
   logic [LATENCY:0]   tv_q, tv_d, tid_q, tid_d;
   logic [1:0]         rsp_valid_q, rsp_valid_d;
   logic [9:0]         rsp_p_q, rsp_p_d;
   logic [1:0]         grant;
   logic               acc, acc_id, emit;
`ifdef BINARY_MUL_ARB_CNT_EN
   logic [15:0]        cnt_q, cnt_d;
`endif

   always_comb begin
      grant       = (req_valid == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req_valid;
      req_ready   = (en && rst_n) ? grant : 2'b00;
      acc         = |(req_valid & req_ready);
      acc_id      = req_ready[1];
      ptr_d       = acc ? ~acc_id : ptr_q;
      mul_a_d     = acc ? (acc_id ? req_a1 : req_a0) : mul_a_q;
      mul_b_d     = acc ? (acc_id ? req_b1 : req_b0) : mul_b_q;
      mul_en_d    = en;
      tv_d        = en ? {tv_q[LATENCY-1:0], acc} : tv_q;
      tid_d       = en ? {tid_q[LATENCY-1:0], acc_id} : tid_q;
      // a tag leaving the last stage only retires on an enabled cycle
      emit        = en && tv_q[LATENCY];
      rsp_valid_d = emit ? (tid_q[LATENCY] ? 2'b10 : 2'b01) : 2'b00;
      rsp_p_d     = emit ? mul_p : rsp_p_q;
`ifdef BINARY_MUL_ARB_CNT_EN
      cnt_d       = acc ? cnt_q + 16'd1 : cnt_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_en_q    <= 1'b0;
         tv_q        <= '0;
         tid_q       <= '0;
         rsp_valid_q <= '0;
         rsp_p_q     <= '0;
`ifdef BINARY_MUL_ARB_CNT_EN
         cnt_q       <= '0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_en_q    <= mul_en_d;
         tv_q        <= tv_d;
         tid_q       <= tid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_p_q     <= rsp_p_d;
`ifdef BINARY_MUL_ARB_CNT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_en    = mul_en_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_p     = rsp_p_q;
`ifdef BINARY_MUL_ARB_CNT_EN
   assign issue_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_binary_mul_5_arb.sv
// tb_binary_mul_5_arb: directed scoreboard bench for binary_mul_5_arb with a
// behavioural pipelined multiplier stalled by mul_en.
module tb_binary_mul_5_arb;
   localparam int LAT = 6;
   logic        clk = 1'b0;
   logic        rst_n, en;
   logic [1:0]  req_valid, req_ready, rsp_valid;
   logic [4:0]  req_a0, req_b0, req_a1, req_b1, mul_a, mul_b;
   logic        mul_en;
   logic [9:0]  mul_p, rsp_p;
`ifdef BINARY_MUL_ARB_CNT_EN
   logic [15:0] issue_cnt;
`endif

   typedef struct {
      logic [1:0] v;
      logic [9:0] p;
      int         due;
   } exp_t;
   exp_t        q[$];
   int          compares = 0;
   int          fails = 0;
   int          cyc = 0;
   logic        ptr_m = 1'b0;
   logic [9:0]  mpipe [LAT];

   binary_mul_5_arb #(.LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
      .rsp_valid(rsp_valid), .rsp_p(rsp_p)
`ifdef BINARY_MUL_ARB_CNT_EN
      , .issue_cnt(issue_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // multiplier: captures its inputs on each mul_en edge, product after LAT stages
   always @(posedge clk) begin
      if (mul_en) begin
         mpipe[0] <= 10'(mul_a) * 10'(mul_b);
         for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
      end
   end
   assign mul_p = mpipe[LAT-1];

   always @(negedge clk) begin
      if (rsp_valid != 2'b00 || (q.size() != 0 && q[0].due <= cyc)) begin
         compares++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL rsp_unexpected: got valid=%b p=%0d at cycle %0d, none expected", rsp_valid, rsp_p, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (rsp_valid !== e.v || rsp_p !== e.p || cyc != e.due) begin
               fails++;
               $display("FAIL rsp: got valid=%b p=%0d cycle=%0d, want valid=%b p=%0d cycle=%0d",
                        rsp_valid, rsp_p, cyc, e.v, e.p, e.due);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      compares++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic drive(input logic e, input logic [1:0] v, input logic [4:0] a0, input logic [4:0] b0,
                        input logic [4:0] a1, input logic [4:0] b1, input int extra);
      logic [1:0] g;
      exp_t       x;
      en = e; req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
      @(negedge clk);
      g = !e ? 2'b00 : (v == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : v;
      chk("req_ready", 16'(req_ready), 16'(g));
      if (g != 2'b00) begin
         x.v   = g;
         x.p   = g[1] ? 10'(a1) * 10'(b1) : 10'(a0) * 10'(b0);
         x.due = cyc + 1 + LAT + 1 + extra;
         q.push_back(x);
         ptr_m = ~g[1];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) idle();
      chk("drain_empty", 16'(q.size()), 16'd0);
   endtask

   task automatic reset_checks();
      chk("rst_req_ready", 16'(req_ready), 16'd0);
      chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
      chk("rst_rsp_p", 16'(rsp_p), 16'd0);
      chk("rst_mul_a", 16'(mul_a), 16'd0);
      chk("rst_mul_b", 16'(mul_b), 16'd0);
      chk("rst_mul_en", 16'(mul_en), 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; req_valid = 2'b11;
      req_a0 = 5'd1; req_b0 = 5'd1; req_a1 = 5'd1; req_b1 = 5'd1;
      #3;
      reset_checks();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle();
      // contention: grants alternate starting with requester 0
      for (int i = 0; i < 8; i++) drive(1'b1, 2'b11, 5'(i), 5'd2, 5'(i), 5'd3, 0);
      drain();
      // single op, largest operands
      drive(1'b1, 2'b01, 5'd31, 5'd31, 5'd0, 5'd0, 0);
      drain();
      // stall three cycles mid-flight
      drive(1'b1, 2'b01, 5'd5, 5'd6, 5'd0, 5'd0, 3);
      idle();
      idle();
      repeat (3) drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      drain();
      // reset mid-flight discards everything in the pipe
      drive(1'b1, 2'b01, 5'd3, 5'd4, 5'd0, 5'd0, 0);
      drive(1'b1, 2'b10, 5'd0, 5'd0, 5'd5, 5'd6, 0);
      drive(1'b1, 2'b01, 5'd7, 5'd8, 5'd0, 5'd0, 0);
      idle();
      idle();
      rst_n = 1'b0; en = 1'b1; req_valid = 2'b11;
      q.delete();
      ptr_m = 1'b0;
      #2;
      reset_checks();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, 2'b11, 5'd7, 5'd9, 5'd1, 5'd1, 0);
      drain();
      // exhaustive operand sweep alternating requesters
      for (int n = 0; n < 1024; n++) begin
         logic [9:0] nv;
         nv = 10'(n);
         if (n % 2 == 0) drive(1'b1, 2'b01, nv[9:5], nv[4:0], 5'd0, 5'd0, 0);
         else            drive(1'b1, 2'b10, 5'd0, 5'd0, nv[9:5], nv[4:0], 0);
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end
endmodule

// File: doc/binary_mul_5_arb.md
BINARY_MUL_5_ARB -- requirements
Module: binary_mul_5_arb

Interface
REQ-001 Parameter LATENCY, default 6, meaning: cycles from multiplier input capture edge to product valid, matching the 5x5 multiplier it drives.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  global enable; low = stall (no grants, multiplier and tag pipe frozen).
REQ-005 req_valid  input  2  per-requester operation valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; transfer when req_valid[i] && req_ready[i] at a rising edge.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  5 each  unsigned operands of requester 0 / 1.
REQ-008 mul_a, mul_b  output  5 each  registered operands to the multiplier's A/B.
REQ-009 mul_en  output  1  multiplier enable.
REQ-010 mul_p  input  10  multiplier product P.
REQ-011 rsp_valid  output  2  one-cycle response strobe to requester i.
REQ-012 rsp_p  output  10  registered product, qualified by rsp_valid.

Function
REQ-013 At most one operation accepted per cycle; req_ready is combinational: req_ready[i] = en && grant[i]; at most one bit of req_ready high.
REQ-014 Arbitration round-robin: with both valid, grant the requester not accepted most recently; with one valid, grant it; pointer updates only on an accepted transfer.
REQ-015 On accept at edge k: mul_a/mul_b load the granted operands at edge k; a tag {valid, id} enters a LATENCY+1 deep shift register at edge k.
REQ-016 Cycles with no accept: mul_a/mul_b hold; a tag with valid=0 enters the shift register.
REQ-017 mul_en registered, equals en delayed one cycle, so the multiplier stalls in lockstep with the tag pipe.
REQ-018 Tag pipe and rsp outputs advance only when en=1; when en=0 all state holds and rsp_valid=0.
REQ-019 Operation accepted at edge k (no stall) produces rsp_valid[id]=1 and rsp_p=mul_p for exactly the one cycle following edge k+LATENCY+1 (7 cycles at default).
REQ-020 Stall cycles (en=0) between accept and response extend latency by exactly the number of stalled cycles.
REQ-021 Responses return in acceptance order; rsp_valid is one-hot or zero; no response backpressure.
REQ-022 Back-to-back accepts every cycle sustain one response per cycle; no bubble inserted.
REQ-023 Product width: 10 bits, unsigned, no truncation (31*31=961 representable).
REQ-024 req_valid deassertion without transfer is legal and drops nothing.

Reset
REQ-025 On rst_n low, immediately: req pointer selects requester 0 first, mul_a=0, mul_b=0, mul_en=0, all tags invalid, rsp_valid=0, rsp_p=0.
REQ-026 Reset mid-operation discards all in-flight tags; no rsp_valid pulse for any operation accepted before reset.
REQ-027 req_ready=0 while rst_n low.

Configuration
REQ-028 Macro BINARY_MUL_ARB_CNT_EN defined: adds output issue_cnt [15:0], reset 0, incremented on each accepted transfer, wraps 65535->0, holds when en=0.
REQ-029 Macro undefined: issue_cnt port and counter absent; all other behaviour identical.

Verification
REQ-030 Single op: req0 A=31,B=31 accepted at edge k -> rsp_valid=2'b01, rsp_p=961 in cycle after edge k+7; no other rsp pulse.
REQ-031 Contention: both valid every cycle for 8 cycles (req0 A=i,B=2; req1 A=i,B=3) -> grants alternate 0,1,0,1..., 8 responses, consecutive cycles, alternating id, correct products.
REQ-032 Stall: accept A=5,B=6, drop en for 3 cycles mid-flight -> rsp_p=30 arrives 3 cycles late, exactly once.
REQ-033 Reset mid-flight: accept 3 ops, assert rst_n low 2 cycles later -> no rsp_valid after reset; next op after release (A=7,B=9) returns 63 with requester 0 granted first on contention.
REQ-034 Exhaustive: all 1024 A/B pairs via alternating requesters -> every rsp_p equals A*B with correct id, in order.
REQ-035 With BINARY_MUL_ARB_CNT_EN: 65537 accepts -> issue_cnt=1.
